pubkey_serializer: RTL and testbench

Downstream stage of the scalar-multiplication block. It captures the final public-key point (X, Y) once upstream signals completion, then streams it out one byte at a time in SEC1 encoding, either compressed (33 bytes) or uncompressed (65 bytes), over a valid/ready byte interface. It feeds the host/UART transmit path and is the only consumer of the point-multiplier's result.

---
 rtl/ecc_pkg.sv | 17 +
 rtl/reg_256.sv | 20 ++
 rtl/pubkey_serializer.sv | 145 ++++++++++++++
 tb/tb_pubkey_serializer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared ECC definitions: SEC1 point-encoding prefix bytes and serializer states.
package ecc_pkg;

    localparam logic [7:0] SEC1_INF    = 8'h00;
    localparam logic [7:0] SEC1_EVEN   = 8'h02;
    localparam logic [7:0] SEC1_ODD    = 8'h03;
    localparam logic [7:0] SEC1_UNCOMP = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFIX,
        ST_XBYTES,
        ST_YBYTES,
        ST_HOLD
    } ser_state_t;

endpackage

// File: rtl/reg_256.sv
// Wide load-enable register with synchronous active-high clear.
module reg_256 #(
    parameter int W = 256
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Load,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Q <= '0;
        end else if (Load) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/pubkey_serializer.sv
// Captures the final public-key point and streams it as SEC1 bytes
// (compressed, uncompressed or the single-byte point at infinity).
module pubkey_serializer
    import ecc_pkg::*;
#(
    parameter int W = 256
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         InValid,
    input  logic [W-1:0] InX,
    input  logic [W-1:0] InY,
    input  logic         Compressed,
    output logic [7:0]   ByteOut,
    output logic         ByteValid,
    input  logic         ByteReady,
    output logic         ByteLast,
    output logic         Busy,
    output logic         PktDone
);

    localparam int NB   = W / 8;
    localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NB - 1);

    // Byte handshake: a byte moves on a rising edge where ByteValid and
    // ByteReady are both high; ByteValid/ByteOut/ByteLast depend only on
    // registered state, so they stay stable while ByteReady is low.
    ser_state_t      state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            comp_q, inf_q, pkt_done_q;
    logic            capture, xfer;
    logic [W-1:0]    x_q, y_q;
    logic [7:0]      x_bytes [NB];
    logic [7:0]      y_bytes [NB];

    reg_256 #(.W(W)) u_reg_x (
        .Clk   (Clk),
        .Reset (Reset),
        .Load  (capture),
        .D     (InX),
        .Q     (x_q)
    );

    reg_256 #(.W(W)) u_reg_y (
        .Clk   (Clk),
        .Reset (Reset),
        .Load  (capture),
        .D     (InY),
        .Q     (y_q)
    );

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            x_bytes[i] = x_q[W-1-8*i -: 8];
            y_bytes[i] = y_q[W-1-8*i -: 8];
        end
    end

    assign ByteValid = (state_q == ST_PREFIX) || (state_q == ST_XBYTES) ||
                       (state_q == ST_YBYTES);
    assign Busy      = ByteValid;
    assign xfer      = ByteValid && ByteReady;
    assign PktDone   = pkt_done_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        capture  = 1'b0;
        ByteOut  = 8'h00;
        ByteLast = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (InValid) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = ST_PREFIX;
                end
            end
            ST_PREFIX: begin
                if (inf_q) begin
                    ByteOut  = SEC1_INF;
                    ByteLast = 1'b1;
                end else if (comp_q) begin
                    ByteOut = y_q[0] ? SEC1_ODD : SEC1_EVEN;
                end else begin
                    ByteOut = SEC1_UNCOMP;
                end
                if (xfer) begin
                    state_d = inf_q ? ST_HOLD : ST_XBYTES;
                end
            end
            ST_XBYTES: begin
                ByteOut  = x_bytes[idx_q];
                ByteLast = comp_q && (idx_q == IDX_LAST);
                if (xfer) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = comp_q ? ST_HOLD : ST_YBYTES;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            ST_YBYTES: begin
                ByteOut  = y_bytes[idx_q];
                ByteLast = (idx_q == IDX_LAST);
                if (xfer) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            ST_HOLD: begin
                // Wait for upstream to drop its level so one result yields one packet.
                if (!InValid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            comp_q     <= 1'b0;
            inf_q      <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pkt_done_q <= xfer && ByteLast;
            if (capture) begin
                comp_q <= Compressed;
                inf_q  <= (InX == '0) && (InY == '0);
            end
        end
    end

endmodule

// File: tb/tb_pubkey_serializer.sv
// Directed bench for pubkey_serializer: expected bytes are queued when a
// point is presented and popped as the DUT transfers each byte.
module tb_pubkey_serializer;

    localparam logic [255:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

    logic         Clk;
    logic         Reset;
    logic         InValid;
    logic [255:0] InX;
    logic [255:0] InY;
    logic         Compressed;
    logic [7:0]   ByteOut;
    logic         ByteValid;
    logic         ByteReady;
    logic         ByteLast;
    logic         Busy;
    logic         PktDone;

    logic [8:0] exp_q[$];
    int n_assert;
    int n_fail;

    pubkey_serializer #(.W(256)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .InValid    (InValid),
        .InX        (InX),
        .InY        (InY),
        .Compressed (Compressed),
        .ByteOut    (ByteOut),
        .ByteValid  (ByteValid),
        .ByteReady  (ByteReady),
        .ByteLast   (ByteLast),
        .Busy       (Busy),
        .PktDone    (PktDone)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input logic [255:0] x, input logic [255:0] y, input logic comp);
        logic [7:0] b;
        if (x == '0 && y == '0) begin
            exp_q.push_back({1'b1, 8'h00});
        end else begin
            if (comp) exp_q.push_back({1'b0, (y[0] ? 8'h03 : 8'h02)});
            else      exp_q.push_back({1'b0, 8'h04});
            for (int i = 0; i < 32; i++) begin
                b = x[255-8*i -: 8];
                exp_q.push_back({(comp && i == 31), b});
            end
            if (!comp) begin
                for (int i = 0; i < 32; i++) begin
                    b = y[255-8*i -: 8];
                    exp_q.push_back({(i == 31), b});
                end
            end
        end
    endtask

    // Consumes one packet; returns bytes transferred and loop iterations used.
    task automatic collect_pkt(input int ready_pct, input bit scramble,
                               output int nbytes, output int ncyc);
        logic [8:0] e;
        logic [7:0] prev_byte;
        logic       prev_last;
        bit         prev_stall, prev_xfer_last, done;
        nbytes = 0;
        ncyc = 0;
        done = 0;
        prev_stall = 0;
        prev_xfer_last = 0;
        prev_byte = 8'h00;
        prev_last = 1'b0;
        while (!done && ncyc < 2000) begin
            @(negedge Clk);
            ncyc++;
            ByteReady = ($urandom_range(99) < ready_pct);
            if (scramble) begin
                InX = {8{$urandom()}};
                InY = {8{$urandom()}};
                Compressed = 1'($urandom_range(1));
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(ByteValid), 32'd1);
                chk("stall_byte", 32'(ByteOut), 32'(prev_byte));
                chk("stall_last", 32'(ByteLast), 32'(prev_last));
            end
            if (!ByteValid) chk("last_without_valid", 32'(ByteLast), 32'd0);
            chk("busy_vs_valid", 32'(Busy), 32'(ByteValid));
            if (PktDone) begin
                chk("pktdone_after_last", 32'(prev_xfer_last), 32'd1);
                chk("queue_drained", 32'(exp_q.size()), 32'd0);
                done = 1;
            end
            prev_xfer_last = 0;
            if (ByteValid && ByteReady) begin
                if (exp_q.size() == 0) begin
                    chk("extra_byte", 32'(ByteOut), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", 32'(ByteOut), 32'(e[7:0]));
                    chk("byte_last", 32'(ByteLast), 32'(e[8]));
                end
                prev_xfer_last = ByteLast;
                nbytes++;
            end
            prev_stall = ByteValid && !ByteReady;
            prev_byte  = ByteOut;
            prev_last  = ByteLast;
        end
        if (!done) chk("pkt_timeout", 32'd0, 32'd1);
        ByteReady = 1'b0;
    endtask

    task automatic check_hold_then_release(input int hold_cycles);
        int vcount;
        vcount = 0;
        @(negedge Clk);
        chk("pktdone_one_cycle", 32'(PktDone), 32'd0);
        chk("hold_busy", 32'(Busy), 32'd0);
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge Clk);
            ByteReady = 1'($urandom_range(1));
            if (ByteValid || PktDone) vcount++;
        end
        chk("no_repeat_packet", 32'(vcount), 32'd0);
        ByteReady = 1'b0;
        InValid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("idle_valid", 32'(ByteValid), 32'd0);
    endtask

    initial begin
        int nb, nc;
        logic [8:0] e;
        logic       comp_r;
        n_assert = 0;
        n_fail = 0;
        Reset = 1'b1;
        InValid = 1'b0;
        InX = '0;
        InY = '0;
        Compressed = 1'b0;
        ByteReady = 1'b0;

        // reset state
        repeat (3) @(negedge Clk);
        chk("rst_byteout", 32'(ByteOut), 32'h00);
        chk("rst_valid", 32'(ByteValid), 32'd0);
        chk("rst_last", 32'(ByteLast), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_pktdone", 32'(PktDone), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // compressed G, full rate: latency n+1, 33 bytes
        InX = GX; InY = GY; Compressed = 1'b1; InValid = 1'b1;
        push_pkt(GX, GY, 1'b1);
        @(negedge Clk);
        chk("latency_valid", 32'(ByteValid), 32'd1);
        chk("latency_prefix", 32'(ByteOut), 32'h02);
        collect_pkt(100, 1'b0, nb, nc);
        chk("comp_bytes", 32'(nb), 32'd33);
        chk("comp_cycles", 32'(nc), 32'd34);
        check_hold_then_release(5);

        // uncompressed G, full rate: 65 bytes
        InX = GX; InY = GY; Compressed = 1'b0; InValid = 1'b1;
        push_pkt(GX, GY, 1'b0);
        collect_pkt(100, 1'b0, nb, nc);
        chk("uncomp_bytes", 32'(nb), 32'd65);
        check_hold_then_release(5);

        // odd Y, compressed: prefix 0x03, inputs scrambled mid-packet
        InX = GX; InY = 256'h1; Compressed = 1'b1; InValid = 1'b1;
        push_pkt(GX, 256'h1, 1'b1);
        collect_pkt(100, 1'b1, nb, nc);
        chk("odd_bytes", 32'(nb), 32'd33);
        check_hold_then_release(5);

        // point at infinity
        InX = '0; InY = '0; Compressed = 1'b1; InValid = 1'b1;
        push_pkt('0, '0, 1'b1);
        collect_pkt(100, 1'b0, nb, nc);
        chk("inf_bytes", 32'(nb), 32'd1);
        check_hold_then_release(5);

        // random backpressure, InValid held ~500 cycles, then a second identical packet
        comp_r = 1'($urandom_range(1));
        for (int rep = 0; rep < 2; rep++) begin
            InX = GX; InY = GY; Compressed = comp_r; InValid = 1'b1;
            push_pkt(GX, GY, comp_r);
            collect_pkt(50, 1'b0, nb, nc);
            chk("rand_bytes", 32'(nb), comp_r ? 32'd33 : 32'd65);
            check_hold_then_release((nc < 480) ? 500 - nc : 20);
        end

        // reset at byte 10 of an uncompressed packet with InValid held high
        InX = GX; InY = GY; Compressed = 1'b0; InValid = 1'b1;
        push_pkt(GX, GY, 1'b0);
        nb = 0;
        nc = 0;
        while (nb < 9 && nc < 100) begin
            @(negedge Clk);
            nc++;
            ByteReady = 1'b1;
            if (ByteValid) begin
                e = exp_q.pop_front();
                chk("pre_rst_byte", 32'(ByteOut), 32'(e[7:0]));
                nb++;
            end
        end
        chk("pre_rst_count", 32'(nb), 32'd9);
        @(negedge Clk);
        ByteReady = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        chk("midrst_valid", 32'(ByteValid), 32'd0);
        chk("midrst_last", 32'(ByteLast), 32'd0);
        chk("midrst_busy", 32'(Busy), 32'd0);
        Reset = 1'b0;
        exp_q.delete();
        push_pkt(GX, GY, 1'b0);
        collect_pkt(100, 1'b0, nb, nc);
        chk("post_rst_bytes", 32'(nb), 32'd65);
        check_hold_then_release(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
